jtkiwi_gfxrom_slots: RTL

- Responder end of the video pipeline's SDRAM graphics-ROM request interface.
- Serves the scroll (scr) and object (obj) fetch ports: each port presents addr/cs and receives 32-bit data with an ok flag.
- Arbitrates misses onto one 16-bit SDRAM read port and assembles two consecutive 16-bit words into each 32-bit reply.
- Sits between the video block and the SDRAM controller.

---
 rtl/jtkiwi_gfxrom_slots.sv | 123 ++++++++++++
 1 files changed

// File: rtl/jtkiwi_gfxrom_slots.sv
// Graphics-ROM responder: two one-entry caches (scroll, object) refilled from a
// 16-bit SDRAM read port, two words per 32-bit entry, one burst in flight.
module jtkiwi_gfxrom_slots #(
  parameter int              AW         = 22,
  parameter logic [AW-1:0]   SCR_OFFSET = AW'(22'h00_0000),
  parameter logic [AW-1:0]   OBJ_OFFSET = AW'(22'h10_0000)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [17:0]   scr_addr,
  input  logic          scr_cs,
  output logic [31:0]   scr_data,
  output logic          scr_ok,
  input  logic [17:0]   obj_addr,
  input  logic          obj_cs,
  output logic [31:0]   obj_data,
  output logic          obj_ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_rd,
  input  logic          sdram_ack,
  input  logic [15:0]   sdram_dout,
  input  logic          sdram_rdy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LO, WAIT_HI} state_t;

  state_t      state;
  logic        rr_obj;     // 1: object slot wins the next tie
  logic        cur_obj;
  logic [17:0] cur_addr;
  logic [15:0] stage;

  logic        scr_valid, obj_valid;
  logic [17:0] scr_tag, obj_tag;

  logic        scr_hit, obj_hit, scr_serv, obj_serv;
  logic        scr_pend, obj_pend, grant_obj;
  logic [AW-1:0] scr_word, obj_word;

  assign scr_hit  = scr_valid && (scr_tag == scr_addr);
  assign obj_hit  = obj_valid && (obj_tag == obj_addr);
  // A slot under refill reports neither hit nor miss, so its data cannot
  // change while ok is high and it is never requested twice.
  assign scr_serv = (state != IDLE) && !cur_obj;
  assign obj_serv = (state != IDLE) &&  cur_obj;
  assign scr_pend = scr_cs && !scr_hit && !scr_serv;
  assign obj_pend = obj_cs && !obj_hit && !obj_serv;

  assign scr_word = SCR_OFFSET + AW'({scr_addr, 1'b0});
  assign obj_word = OBJ_OFFSET + AW'({obj_addr, 1'b0});

  always_comb begin
    // NOTE: give every always_comb output a default first so no path infers a latch.
    grant_obj = obj_pend;
    if (scr_pend && obj_pend) grant_obj = rr_obj;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_obj     <= 1'b0;
      cur_obj    <= 1'b0;
      cur_addr   <= '0;
      stage      <= '0;
      scr_valid  <= 1'b0;
      obj_valid  <= 1'b0;
      scr_tag    <= '0;
      obj_tag    <= '0;
      scr_data   <= '0;
      obj_data   <= '0;
      scr_ok     <= 1'b0;
      obj_ok     <= 1'b0;
      sdram_rd   <= 1'b0;
      sdram_addr <= '0;
    end else begin
      scr_ok <= scr_cs && scr_hit && !scr_serv;
      obj_ok <= obj_cs && obj_hit && !obj_serv;

      unique case (state)
        IDLE: begin
          if (scr_pend || obj_pend) begin
            cur_obj    <= grant_obj;
            cur_addr   <= grant_obj ? obj_addr : scr_addr;
            sdram_addr <= grant_obj ? obj_word : scr_word;
            sdram_rd   <= 1'b1;
            if (scr_pend && obj_pend) rr_obj <= !rr_obj;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_rd <= 1'b0;
            state    <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (sdram_rdy) begin
            stage <= sdram_dout;
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (sdram_rdy) begin
            if (cur_obj) begin
              obj_data  <= {sdram_dout, stage};
              obj_tag   <= cur_addr;
              obj_valid <= 1'b1;
            end else begin
              scr_data  <= {sdram_dout, stage};
              scr_tag   <= cur_addr;
              scr_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
